inst_wait_stage: RTL and testbench

- IF_wait stage, directly downstream of fetch_stage and upstream of decode.
- Takes each entry fetch_stage hands over (pc, exception info, cancelled flag) and waits for the matching inst_data_ok/inst_rdata.
- Drains or discards entries flushed by commit_i.
- Presents the instruction word to decode under a valid/ready handshake.
- Includes a one-entry early-data buffer, because read data can arrive before its entry is accepted.

---
 rtl/inst_wait_stage.sv | 190 +++++++++++++++++++
 tb/tb_inst_wait_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_wait_stage.sv
// inst_wait_stage
//   Sits between fetch_stage and decode. It holds one fetched entry (pc plus
//   exception info) until the matching instruction read data arrives. Then it
//   presents the instruction word to decode. A one-entry early buffer catches
//   read data that arrives before the entry it belongs to has been accepted.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
//   high at the rising clock edge. valid_o never waits for ready_i. ready_o
//   may depend on ready_i, but it never depends on valid_i.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   inst_data_ok, inst_rdata   instruction read response, in request order
//   valid_i, pc_i, cancelled_i, exc_i, exc_miss_i, exccode_i, ready_o
//                              entry handed over by fetch_stage
//   commit_i                   pipeline flush
//   valid_o, ready_i, pc_o, inst_o, exc_o, exc_miss_o, exccode_o
//                              entry presented to decode
//   perfcnt_wait_data          cycles spent in WAIT with no data arriving
//   dbg_st, dbg_ebuf_v         state register and early-buffer valid, for observation
module inst_wait_stage #(
   parameter logic [31:0] EXC_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        valid_i,
   input  logic [31:0] pc_i,
   input  logic        cancelled_i,
   input  logic        exc_i,
   input  logic        exc_miss_i,
   input  logic [4:0]  exccode_i,
   output logic        ready_o,
   input  logic        commit_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        exc_o,
   output logic        exc_miss_o,
   output logic [4:0]  exccode_o,
   output logic [31:0] perfcnt_wait_data,
   output logic [1:0]  dbg_st,
   output logic        dbg_ebuf_v
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } st_t;

   st_t         st, st_nxt;

   // Entry registers
   logic [31:0] pc;
   logic        exc;
   logic        exc_miss;
   logic [4:0]  exccode;
   logic        drop;
   logic [31:0] ibuf;

   // Early-data buffer
   logic [31:0] ebuf;
   logic        ebuf_v;

   logic [31:0] perfcnt;

   // Combinational control
   logic        deliver;
   logic        leave;
   logic        accept;
   logic        ebuf_take;      // accepted entry takes its word from ebuf
   logic        data_to_entry;  // data this cycle belongs to the entry being accepted
   logic        ebuf_load;      // data this cycle belongs to a future entry

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= ST_EMPTY;
      else       st <= st_nxt;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      st_nxt = st;
      if (accept) begin
         if (exc_i)                                st_nxt = ST_HOLD;
         else if (ebuf_v)                          st_nxt = ST_HOLD;
         else if (inst_data_ok && st != ST_WAIT)   st_nxt = ST_HOLD;
         else                                      st_nxt = ST_WAIT;
      end else if (leave) begin
         st_nxt = ST_EMPTY;
      end else if (st == ST_WAIT && inst_data_ok) begin
         // Data arrived but was not taken (back-pressure or flush).
         st_nxt = ST_HOLD;
      end
   end

   // ---------------------------------------------------------------------
   // Output / control logic
   // ---------------------------------------------------------------------
   always_comb begin
      deliver = ((st == ST_HOLD) && !drop) ||
                ((st == ST_WAIT) && inst_data_ok && !drop);
      // Data arriving in WAIT is bypassed straight through to decode.
      valid_o = deliver && !commit_i;

      if (st == ST_HOLD) inst_o = exc ? EXC_INST : ibuf;
      else               inst_o = inst_rdata;

      leave = (valid_o && ready_i) ||
              ((st == ST_HOLD) && commit_i) ||
              ((st == ST_WAIT) && inst_data_ok && drop) ||
              ((st == ST_HOLD) && drop);

      ready_o = (st == ST_EMPTY) || leave;
      accept  = valid_i && ready_o;

      // In WAIT the response belongs to the held entry. Otherwise it belongs
      // to the next non-exception entry. That entry may be accepted in this
      // same cycle; if not, the word is parked in ebuf.
      ebuf_take     = accept && !exc_i && ebuf_v;
      data_to_entry = accept && !exc_i && !ebuf_v && inst_data_ok && (st != ST_WAIT);
      ebuf_load     = inst_data_ok && (st != ST_WAIT) && !data_to_entry;

      pc_o              = pc;
      exc_o             = exc;
      exc_miss_o        = exc_miss;
      exccode_o         = exccode;
      perfcnt_wait_data = perfcnt;
      dbg_st            = st;
      dbg_ebuf_v        = ebuf_v;
   end

   // ---------------------------------------------------------------------
   // Entry, early buffer and counter registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= '0;
         exc      <= 1'b0;
         exc_miss <= 1'b0;
         exccode  <= '0;
         drop     <= 1'b0;
         ibuf     <= '0;
         ebuf     <= '0;
         ebuf_v   <= 1'b0;
         perfcnt  <= '0;
      end else begin
         // ebuf is deliberately left alone on commit_i. The response still
         // pairs with the next accepted entry, which fetch marks cancelled.
         if (ebuf_load) begin
            ebuf   <= inst_rdata;
            ebuf_v <= 1'b1;
         end else if (ebuf_take) begin
            ebuf_v <= 1'b0;
         end

         if (accept) begin
            pc       <= pc_i;
            exc      <= exc_i;
            exc_miss <= exc_miss_i;
            exccode  <= exccode_i;
            drop     <= cancelled_i || commit_i;
            if (ebuf_take)          ibuf <= ebuf;
            else if (data_to_entry) ibuf <= inst_rdata;
         end else if (leave) begin
            drop <= 1'b0;
         end else if (st == ST_WAIT && inst_data_ok) begin
            ibuf <= inst_rdata;
            drop <= drop || commit_i;
         end else if (st == ST_WAIT && commit_i) begin
            // The request is still outstanding; its data must be absorbed.
            drop <= 1'b1;
         end

         if (st == ST_WAIT && !inst_data_ok) perfcnt <= perfcnt + 32'd1;
      end
   end

   // A response that arrives while ebuf is already full has nowhere to go.
   a_ebuf_overflow : assert property (@(posedge clk) disable iff (reset)
      !(inst_data_ok && ebuf_v && st != ST_WAIT));

endmodule

// File: tb/tb_inst_wait_stage.sv
module tb_inst_wait_stage;

   localparam logic [1:0] E = 2'd0;
   localparam logic [1:0] W = 2'd1;
   localparam logic [1:0] H = 2'd2;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_TLBL = 5'd2;
   localparam logic [31:0] EXC_WORD = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        valid_i;
   logic [31:0] pc_i;
   logic        cancelled_i;
   logic        exc_i;
   logic        exc_miss_i;
   logic [4:0]  exccode_i;
   logic        ready_o;
   logic        commit_i;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        exc_o;
   logic        exc_miss_o;
   logic [4:0]  exccode_o;
   logic [31:0] perfcnt_wait_data;
   logic [1:0]  dbg_st;
   logic        dbg_ebuf_v;

   int checks = 0;
   int errors = 0;

   inst_wait_stage #(.EXC_INST(EXC_WORD)) dut (
      .clk(clk), .reset(reset),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .valid_i(valid_i), .pc_i(pc_i), .cancelled_i(cancelled_i),
      .exc_i(exc_i), .exc_miss_i(exc_miss_i), .exccode_i(exccode_i),
      .ready_o(ready_o), .commit_i(commit_i), .ready_i(ready_i),
      .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .exc_o(exc_o),
      .exc_miss_o(exc_miss_o), .exccode_o(exccode_o),
      .perfcnt_wait_data(perfcnt_wait_data),
      .dbg_st(dbg_st), .dbg_ebuf_v(dbg_ebuf_v)
   );

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------------
   // Vector record: one row is one clock cycle
   // ---------------------------------------------------------------------
   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        canc;
      logic        exc;
      logic        miss;
      logic [4:0]  code;
      logic        dok;
      logic [31:0] rd;
      logic        cm;
      logic        rdy;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_exc;
      logic        e_miss;
      logic [4:0]  e_code;
      logic [1:0]  e_st;
      logic        e_ebv;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic v, input logic [31:0] pc, input logic canc, input logic exc,
      input logic miss, input logic [4:0] code, input logic dok,
      input logic [31:0] rd, input logic cm, input logic rdy,
      input logic e_rdy, input logic e_vld, input logic [31:0] e_pc,
      input logic [31:0] e_inst, input logic e_exc, input logic e_miss,
      input logic [4:0] e_code, input logic [1:0] e_st, input logic e_ebv);
      vec_t r;
      r.v = v; r.pc = pc; r.canc = canc; r.exc = exc; r.miss = miss;
      r.code = code; r.dok = dok; r.rd = rd; r.cm = cm; r.rdy = rdy;
      r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_pc = e_pc; r.e_inst = e_inst;
      r.e_exc = e_exc; r.e_miss = e_miss; r.e_code = e_code;
      r.e_st = e_st; r.e_ebv = e_ebv;
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Driver and compare
   // ---------------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      valid_i      = x.v;
      pc_i         = x.pc;
      cancelled_i  = x.canc;
      exc_i        = x.exc;
      exc_miss_i   = x.miss;
      exccode_i    = x.code;
      inst_data_ok = x.dok;
      inst_rdata   = x.rd;
      commit_i     = x.cm;
      ready_i      = x.rdy;
   endtask

   // Drive one row, compare mid-cycle, then advance past the next edge.
   task automatic apply(input vec_t x, input string tag);
      drive(x);
      @(negedge clk);
      chk({tag, " ready_o"}, {31'd0, ready_o}, {31'd0, x.e_rdy});
      chk({tag, " valid_o"}, {31'd0, valid_o}, {31'd0, x.e_vld});
      chk({tag, " st"},      {30'd0, dbg_st},  {30'd0, x.e_st});
      chk({tag, " ebuf_v"},  {31'd0, dbg_ebuf_v}, {31'd0, x.e_ebv});
      if (x.e_vld) begin
         chk({tag, " pc_o"},       pc_o,               x.e_pc);
         chk({tag, " inst_o"},     inst_o,             x.e_inst);
         chk({tag, " exc_o"},      {31'd0, exc_o},     {31'd0, x.e_exc});
         chk({tag, " exc_miss_o"}, {31'd0, exc_miss_o}, {31'd0, x.e_miss});
         chk({tag, " exccode_o"},  {27'd0, exccode_o}, {27'd0, x.e_code});
      end
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t idle(input logic rdy, input logic e_rdy, input logic [1:0] e_st,
                                 input logic e_ebv);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, e_rdy, 0, 0, 0, 0, 0, 0, e_st, e_ebv);
   endfunction

   // ---------------------------------------------------------------------
   // Test
   // ---------------------------------------------------------------------
   initial begin
      logic [31:0] exp_perf;

      // row fields: v pc canc exc miss code dok rdata commit rdy |
      //             ready valid pc inst exc miss code st ebuf_v
      // Bypass
      vecs.push_back(idle(1, 1, E, 0));
      vecs.push_back(mk(1, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3C1D_0001, 0, 1,
                        1, 1, 32'hBFC0_0000, 32'h3C1D_0001, 0, 0, 0, W, 0));
      // Early data
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h2402_0005, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(1, 32'hBFC0_0004, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                        1, 1, 32'hBFC0_0004, 32'h2402_0005, 0, 0, 0, H, 0));
      // Back-pressure: A held, B's data parked in ebuf, both delivered in order
      vecs.push_back(mk(1, 32'hBFC0_0008, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(1, 32'hBFC0_000C, 0, 0, 0, 0, 1, 32'h1111_1111, 0, 0,
                        0, 1, 32'hBFC0_0008, 32'h1111_1111, 0, 0, 0, W, 0));
      vecs.push_back(mk(1, 32'hBFC0_000C, 0, 0, 0, 0, 1, 32'h2222_2222, 0, 0,
                        0, 1, 32'hBFC0_0008, 32'h1111_1111, 0, 0, 0, H, 0));
      vecs.push_back(mk(1, 32'hBFC0_000C, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 1, 32'hBFC0_0008, 32'h1111_1111, 0, 0, 0, H, 1));
      vecs.push_back(mk(1, 32'hBFC0_000C, 0, 0, 0, 0, 0, 0, 0, 1,
                        1, 1, 32'hBFC0_0008, 32'h1111_1111, 0, 0, 0, H, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                        1, 1, 32'hBFC0_000C, 32'h2222_2222, 0, 0, 0, H, 0));
      // Exception entry, no data consumed
      vecs.push_back(mk(1, 32'h0000_0001, 0, 1, 0, EXC_ADEL, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                        1, 1, 32'h0000_0001, EXC_WORD, 1, 0, EXC_ADEL, H, 0));
      // Exception entry accepted while ebuf is full: ebuf kept for next entry
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3333_3333, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(1, 32'hBFC0_0010, 0, 1, 1, EXC_TLBL, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, E, 1));
      vecs.push_back(mk(1, 32'hBFC0_0014, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 1, 32'hBFC0_0010, EXC_WORD, 1, 1, EXC_TLBL, H, 1));
      vecs.push_back(mk(1, 32'hBFC0_0014, 0, 0, 0, 0, 0, 0, 0, 1,
                        1, 1, 32'hBFC0_0010, EXC_WORD, 1, 1, EXC_TLBL, H, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                        1, 1, 32'hBFC0_0014, 32'h3333_3333, 0, 0, 0, H, 0));
      // Cancelled exception entry drops without waiting
      vecs.push_back(mk(1, 32'hBFC0_0018, 1, 1, 0, EXC_ADEL, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(idle(0, 1, H, 0));
      // Commit while HOLD (data arrived with acceptance)
      vecs.push_back(mk(1, 32'hBFC0_001C, 0, 0, 0, 0, 1, 32'h4444_4444, 0, 0,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, H, 0));
      vecs.push_back(idle(1, 1, E, 0));
      // Cancelled non-exception entry absorbs its data silently
      vecs.push_back(mk(1, 32'hBFC0_0020, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555, 0, 1,  1, 0, 0, 0, 0, 0, 0, W, 0));
      vecs.push_back(idle(1, 1, E, 0));
      // Data arriving in WAIT together with commit: parked as dropped, then freed
      vecs.push_back(mk(1, 32'hBFC0_0024, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h6666_6666, 1, 1,  0, 0, 0, 0, 0, 0, 0, W, 0));
      vecs.push_back(idle(0, 1, H, 0));
      // Back-to-back: deliver from WAIT and accept the next entry in one cycle
      vecs.push_back(mk(1, 32'hBFC0_0028, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0));
      vecs.push_back(mk(1, 32'hBFC0_002C, 0, 0, 0, 0, 1, 32'h7777_7777, 0, 1,
                        1, 1, 32'hBFC0_0028, 32'h7777_7777, 0, 0, 0, W, 0));
      vecs.push_back(idle(1, 0, W, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h8888_8888, 0, 1,
                        1, 1, 32'hBFC0_002C, 32'h8888_8888, 0, 0, 0, W, 0));

      // Reset state
      drive(idle(1, 1, E, 0));
      reset = 1'b1;
      #2;
      chk("reset valid_o", {31'd0, valid_o}, 32'd0);
      chk("reset ready_o", {31'd0, ready_o}, 32'd1);
      chk("reset st", {30'd0, dbg_st}, {30'd0, E});
      chk("reset ebuf_v", {31'd0, dbg_ebuf_v}, 32'd0);
      chk("reset perfcnt", perfcnt_wait_data, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], $sformatf("vec%0d", i));

      // Only the cycle in vec32 was spent waiting with no data.
      exp_perf = 32'd1;
      chk("perfcnt after table", perfcnt_wait_data, exp_perf);

      // Flush in WAIT: commit, then data three cycles later is discarded.
      apply(mk(1, 32'hBFC0_0030, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0), "flush accept");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, W, 0), "flush commit");
      apply(idle(1, 0, W, 0), "flush wait1");
      apply(idle(1, 0, W, 0), "flush wait2");
      apply(mk(0, 0, 0, 0, 0, 0, 1, 32'h9999_9999, 0, 1,  1, 0, 0, 0, 0, 0, 0, W, 0), "flush data");
      exp_perf = exp_perf + 32'd3;
      apply(idle(1, 1, E, 0), "flush done");
      chk("flush perfcnt", perfcnt_wait_data, exp_perf);

      // Asynchronous reset in the middle of a WAIT cycle
      apply(mk(1, 32'hBFC0_0040, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0), "rst accept");
      drive(idle(1, 0, W, 0));
      @(negedge clk);
      chk("rst pre st", {30'd0, dbg_st}, {30'd0, W});
      chk("rst pre ready_o", {31'd0, ready_o}, 32'd0);
      #1;
      reset = 1'b1;
      #1;
      chk("rst mid valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst mid ready_o", {31'd0, ready_o}, 32'd1);
      chk("rst mid st", {30'd0, dbg_st}, {30'd0, E});
      chk("rst mid perfcnt", perfcnt_wait_data, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Asynchronous reset clears a full early buffer
      apply(mk(0, 0, 0, 0, 0, 0, 1, 32'hAAAA_AAAA, 0, 1,  1, 0, 0, 0, 0, 0, 0, E, 0), "rst ebuf load");
      drive(idle(1, 1, E, 1));
      @(negedge clk);
      chk("rst ebuf pre", {31'd0, dbg_ebuf_v}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("rst ebuf mid", {31'd0, dbg_ebuf_v}, 32'd0);
      chk("rst ebuf ready_o", {31'd0, ready_o}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      apply(idle(1, 1, E, 0), "post reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
